// File: rtl/mxv_pkg.sv
// +----------------------------------------------------------------------+
// | mxv_pkg: shared constants and tx-framer state type for the MxV unit  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mxv_pkg;

    localparam logic [7:0] SOF_BYTE   = 8'hFE;
    localparam logic [7:0] EOF_BYTE   = 8'hEF;
    localparam logic [7:0] CMD_RESULT = 8'h05;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SOF   = 4'd1,
        LEN   = 4'd2,
        CMD   = 4'd3,
        FETCH = 4'd4,
        LATCH = 4'd5,
        HI    = 4'd6,
        LO    = 4'd7,
        CHK   = 4'd8,
        EOF   = 4'd9
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/mxv_tx_byte_mux.sv
// +----------------------------------------------------------------------+
// | mxv_tx_byte_mux: selects the outgoing frame byte for the current     |
// | framer state. Revision: 1.0                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module mxv_tx_byte_mux
    import mxv_pkg::*;
(
    input  tx_state_t   state,
    input  logic [7:0]  len,
    input  logic [15:0] word,
    input  logic [7:0]  chk,
    output logic [7:0]  tx_data
);

    always_comb begin
        tx_data = 8'h00;
        case (state)
            SOF:     tx_data = SOF_BYTE;
            LEN:     tx_data = len;
            CMD:     tx_data = CMD_RESULT;
            HI:      tx_data = word[15:8];
            LO:      tx_data = word[7:0];
            CHK:     tx_data = chk;
            EOF:     tx_data = EOF_BYTE;
            default: tx_data = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mxv_result_tx.sv
// +----------------------------------------------------------------------+
// | mxv_result_tx: reads N result words and sends them as one UART       |
// | response frame. Optional checksum byte: define MXV_TX_CHECKSUM_EN.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mxv_result_tx
    import mxv_pkg::*;
#(
    parameter int MAX_N = 8,
    parameter int AW    = $clog2(MAX_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    N_input,
    output logic          res_rd,
    output logic [AW-1:0] res_addr,
    input  logic [15:0]   res_data,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [7:0] c_max_n = 8'(MAX_N);

    tx_state_t     r_state;
    logic [AW-1:0] r_idx;
    logic [7:0]    r_n;
    logic [7:0]    r_len;
    logic [15:0]   r_word;
    logic          r_done;
    logic          r_err;
    logic [7:0]    w_chk;
    logic [7:0]    w_len;
    logic          w_n_legal;
    logic          w_more;

    assign w_n_legal = (N_input != 8'd0) && (N_input <= c_max_n);
    assign w_more    = ((8'(r_idx) + 8'd1) < r_n);

`ifdef MXV_TX_CHECKSUM_EN
    logic [7:0] r_chk;
    assign w_len = {N_input[6:0], 1'b0} + 8'd2;
    assign w_chk = r_chk;
`else
    assign w_len = {N_input[6:0], 1'b0} + 8'd1;
    assign w_chk = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_n     <= 8'd0;
            r_len   <= 8'd0;
            r_word  <= 16'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MXV_TX_CHECKSUM_EN
            r_chk   <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_n_legal) begin
                            r_n     <= N_input;
                            r_len   <= w_len;
                            r_idx   <= '0;
                            r_state <= SOF;
`ifdef MXV_TX_CHECKSUM_EN
                            r_chk   <= w_len ^ CMD_RESULT;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                SOF:   if (tx_ready) r_state <= LEN;
                LEN:   if (tx_ready) r_state <= CMD;
                CMD:   if (tx_ready) r_state <= FETCH;
                FETCH: r_state <= LATCH;
                LATCH: begin
                    r_word  <= res_data;
`ifdef MXV_TX_CHECKSUM_EN
                    r_chk   <= r_chk ^ res_data[15:8] ^ res_data[7:0];
`endif
                    r_state <= HI;
                end
                HI:    if (tx_ready) r_state <= LO;
                LO: begin
                    if (tx_ready) begin
                        if (w_more) begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= FETCH;
                        end else begin
`ifdef MXV_TX_CHECKSUM_EN
                            r_state <= CHK;
`else
                            r_state <= EOF;
`endif
                        end
                    end
                end
                CHK:   if (tx_ready) r_state <= EOF;
                EOF: begin
                    if (tx_ready) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode directly from state so reset drops them at once.
    assign tx_valid = r_state inside {SOF, LEN, CMD, HI, LO, CHK, EOF};
    assign busy     = (r_state != IDLE);
    assign res_rd   = (r_state == FETCH);
    assign res_addr = r_idx;
    assign done     = r_done;
    assign err      = r_err;

    mxv_tx_byte_mux u_byte_mux (
        .state   (r_state),
        .len     (r_len),
        .word    (r_word),
        .chk     (w_chk),
        .tx_data (tx_data)
    );

endmodule

`default_nettype wire
